// File: rtl/cluster_count_tree_pkg.sv
// Shared constants and elaboration-time helpers for cluster_count_tree.
// LEAF_W  : bits popcounted per leaf
// LEAF_CW : leaf count width (0..6 fits in 3 bits)
// clog2 / nleaf / nstg / cnt_w / nodes_at : geometry derived from WIDTH
package cluster_count_tree_pkg;

  localparam int LEAF_W  = 6;
  localparam int LEAF_CW = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // number of 6-bit leaves
  function automatic int nleaf(input int width);
    return (width + LEAF_W - 1) / LEAF_W;
  endfunction

  // number of adder-tree levels above the leaves
  function automatic int nstg(input int width);
    return clog2(nleaf(width));
  endfunction

  // width of a count that can hold 0..width
  function automatic int cnt_w(input int width);
    return clog2(width + 1);
  endfunction

  // elements at tree level lvl (0 = leaves)
  function automatic int nodes_at(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/cluster_count_tree_popcount6.sv
// Registered 6-bit popcount leaf.
// clock/reset : rising edge, synchronous active-high reset
// bits        : 6 input flags
// cnt         : number of set bits, one cycle later
module popcount6
  import cluster_count_tree_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [LEAF_W-1:0]  bits,
  output logic [LEAF_CW-1:0] cnt
);

  logic [LEAF_CW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < LEAF_W; i++) sum = sum + LEAF_CW'(bits[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else       cnt <= sum;
  end

endmodule

// File: rtl/cluster_count_tree.sv
// Pipelined population count of a wide valid-flag word with threshold
// overflow detection, running peak and saturating overflow-event counter.
// clock, reset : rising edge, synchronous active-high reset
// vpfs_i       : WIDTH flag bits, one word per cycle (fully streaming)
// valid_i      : qualifies vpfs_i
// thresh_i     : overflow threshold, travels with its word
// clear_i      : clears peak_o / ovf_cnt_o (applied before same-cycle update)
// cnt_o        : popcount, LATENCY = NSTG+3 cycles after input
// valid_o      : valid_i delayed by LATENCY
// overflow_o   : cnt_o > threshold of the same word
// peak_o       : max valid cnt_o since reset/clear
// ovf_cnt_o    : saturating count of valid overflowing words
module cluster_count_tree
  import cluster_count_tree_pkg::*;
#(
  parameter  int WIDTH     = 768,
  parameter  int OVF_CNT_W = 16,
  localparam int CNT_W     = cnt_w(WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     vpfs_i,
  input  logic                 valid_i,
  input  logic [CNT_W-1:0]     thresh_i,
  input  logic                 clear_i,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 valid_o,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     peak_o,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o
);

  localparam int NLEAF  = nleaf(WIDTH);
  localparam int NSTG   = nstg(WIDTH);
  localparam int STAGES = NSTG + 2;          // vld_pipe[STAGES] is the output stage
  localparam int ROOT_W = LEAF_CW + NSTG;
  localparam int PAD_W  = NLEAF * LEAF_W;
  localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

  // Input register kept distinct so fan-out duplication is not merged away.
  (* keep = "true" *) logic [WIDTH-1:0] vpf_q;
  logic [STAGES:0]               vld_pipe;
  logic [NSTG+1:0][CNT_W-1:0]    thr_pipe;  // thr_pipe[k] aligned with stage k

  always_ff @(posedge clock) begin
    if (reset) begin
      vpf_q    <= '0;
      vld_pipe <= '0;
      thr_pipe <= '0;
    end else begin
      vpf_q    <= vpfs_i;
      vld_pipe <= {vld_pipe[STAGES-1:0], valid_i};
      thr_pipe <= {thr_pipe[NSTG:0], thresh_i};
    end
  end

  logic [PAD_W-1:0] pad;
  assign pad = PAD_W'(vpf_q);

  // Level 0 = leaves, level l holds ceil(NLEAF/2^l) sums of width 3+l.
  for (genvar l = 0; l <= NSTG; l++) begin : g_lvl
    localparam int N = nodes_at(NLEAF, l);
    localparam int W = LEAF_CW + l;
    logic [N-1:0][W-1:0] sum;

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_pc
        popcount6 u_pc (
          .clock (clock),
          .reset (reset),
          .bits  (pad[i*LEAF_W +: LEAF_W]),
          .cnt   (sum[i])
        );
      end
    end else begin : g_add
      // Previous level zero-extended to an even count: an odd last
      // element is simply added to zero.
      logic [2*N-1:0][W-2:0] prev;
      assign prev = (2*N*(W-1))'(g_lvl[l-1].sum);

      always_ff @(posedge clock) begin
        if (reset) sum <= '0;
        else
          for (int i = 0; i < N; i++)
            sum[i] <= W'(prev[2*i]) + W'(prev[2*i+1]);
      end
    end
  end

  // Root never exceeds WIDTH, so the low CNT_W bits carry the full value.
  logic [ROOT_W-1:0] root;
  logic [CNT_W-1:0]  root_cnt;
  assign root     = g_lvl[NSTG].sum[0];
  assign root_cnt = root[CNT_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      cnt_o      <= root_cnt;
      overflow_o <= root_cnt > thr_pipe[NSTG+1];
    end
  end

  assign valid_o = vld_pipe[STAGES];

  // Statistics: clear first, then fold in the word on the output.
  logic [CNT_W-1:0]     peak_nxt;
  logic [OVF_CNT_W-1:0] ovf_nxt;

  always_comb begin
    peak_nxt = clear_i ? '0 : peak_o;
    ovf_nxt  = clear_i ? '0 : ovf_cnt_o;
    if (valid_o) begin
      if (cnt_o > peak_nxt) peak_nxt = cnt_o;
      if (overflow_o && ovf_nxt != OVF_MAX) ovf_nxt = ovf_nxt + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_o    <= '0;
      ovf_cnt_o <= '0;
    end else begin
      peak_o    <= peak_nxt;
      ovf_cnt_o <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cluster_count_tree.sv
// Directed bench: A = WIDTH 768, C = WIDTH 768 / OVF_CNT_W 2 (shares A's
// inputs), B = WIDTH 100.
module tb_cluster_count_tree;

  localparam int LAT_A = 10;
  localparam int LAT_B = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [767:0] a_vpf;
  logic         a_valid, a_clear;
  logic [9:0]   a_thr;
  logic [9:0]   a_cnt_o, a_peak_o, c_cnt_o, c_peak_o;
  logic         a_valid_o, a_ovf_o, c_valid_o, c_ovf_o;
  logic [15:0]  a_ovfc_o;
  logic [1:0]   c_ovfc_o;

  logic [99:0]  b_vpf;
  logic         b_valid, b_clear;
  logic [6:0]   b_thr, b_cnt_o, b_peak_o;
  logic         b_valid_o, b_ovf_o;
  logic [15:0]  b_ovfc_o;

  cluster_count_tree #(.WIDTH(768), .OVF_CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .vpfs_i(a_vpf), .valid_i(a_valid),
    .thresh_i(a_thr), .clear_i(a_clear), .cnt_o(a_cnt_o), .valid_o(a_valid_o),
    .overflow_o(a_ovf_o), .peak_o(a_peak_o), .ovf_cnt_o(a_ovfc_o));

  cluster_count_tree #(.WIDTH(768), .OVF_CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .vpfs_i(a_vpf), .valid_i(a_valid),
    .thresh_i(a_thr), .clear_i(a_clear), .cnt_o(c_cnt_o), .valid_o(c_valid_o),
    .overflow_o(c_ovf_o), .peak_o(c_peak_o), .ovf_cnt_o(c_ovfc_o));

  cluster_count_tree #(.WIDTH(100), .OVF_CNT_W(16)) u_b (
    .clock(clock), .reset(reset), .vpfs_i(b_vpf), .valid_i(b_valid),
    .thresh_i(b_thr), .clear_i(b_clear), .cnt_o(b_cnt_o), .valid_o(b_valid_o),
    .overflow_o(b_ovf_o), .peak_o(b_peak_o), .ovf_cnt_o(b_ovfc_o));

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One isolated word through A: exact latency, value, then statistics.
  task automatic send_a(input logic [767:0] v, input logic [9:0] thr,
                        input logic [9:0] ec, input logic eo,
                        input logic [9:0] ep, input logic [15:0] eoc, input string nm);
    @(negedge clock);
    a_vpf = v; a_thr = thr; a_valid = 1'b1;
    @(negedge clock);
    a_vpf = '0; a_valid = 1'b0;
    repeat (LAT_A - 2) @(negedge clock);
    check({nm, "_early_valid"}, 32'(a_valid_o), 0);
    @(negedge clock);
    check({nm, "_valid"}, 32'(a_valid_o), 1);
    check({nm, "_cnt"},   32'(a_cnt_o), 32'(ec));
    check({nm, "_ovf"},   32'(a_ovf_o), 32'(eo));
    @(negedge clock);
    check({nm, "_peak"},  32'(a_peak_o), 32'(ep));
    check({nm, "_ovfc"},  32'(a_ovfc_o), 32'(eoc));
  endtask

  typedef struct {
    logic [767:0] v;
    logic [9:0]   thr;
    logic [9:0]   cnt;
    logic         ovf;
    logic [9:0]   peak;
    logic [15:0]  ovfc;
  } vec_t;

  vec_t tbl [9];
  logic [767:0] ones, alt, top6, hi1;
  int seen;

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ones = '1;
    alt  = {384{2'b01}};
    top6 = {6'b111111, 762'b0};
    hi1  = {1'b1, 767'b0};
    tbl[0] = '{768'b0, 10'd0,   10'd0,   1'b0, 10'd0,   16'd0};
    tbl[1] = '{ones,   10'd0,   10'd768, 1'b1, 10'd768, 16'd1};
    tbl[2] = '{768'hF, 10'd4,   10'd4,   1'b0, 10'd768, 16'd1};
    tbl[3] = '{hi1,    10'd0,   10'd1,   1'b1, 10'd768, 16'd2};
    tbl[4] = '{alt,    10'd384, 10'd384, 1'b0, 10'd768, 16'd2};
    tbl[5] = '{alt,    10'd383, 10'd384, 1'b1, 10'd768, 16'd3};
    tbl[6] = '{ones,   10'd767, 10'd768, 1'b1, 10'd768, 16'd4};
    tbl[7] = '{ones,   10'd768, 10'd768, 1'b0, 10'd768, 16'd4};
    tbl[8] = '{top6,   10'd5,   10'd6,   1'b1, 10'd768, 16'd5};

    reset = 1'b1;
    a_vpf = '0; a_valid = 1'b0; a_thr = '0; a_clear = 1'b0;
    b_vpf = '0; b_valid = 1'b0; b_thr = 7'd50; b_clear = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cnt",   32'(a_cnt_o), 0);
    check("rst_valid", 32'(a_valid_o), 0);
    check("rst_peak",  32'(a_peak_o), 0);
    check("rst_ovfc",  32'(a_ovfc_o), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      send_a(tbl[i].v, tbl[i].thr, tbl[i].cnt, tbl[i].ovf, tbl[i].peak, tbl[i].ovfc,
             $sformatf("tbl%0d", i));

    // Standalone clear with no valid output.
    @(negedge clock); a_clear = 1'b1;
    @(negedge clock); a_clear = 1'b0;
    check("clr_peak",  32'(a_peak_o), 0);
    check("clr_ovfc",  32'(a_ovfc_o), 0);
    check("clr_ovfc2", 32'(c_ovfc_o), 0);

    // Back-to-back words 4,5,3 with thr 4; clear lands on the 3-bit word.
    @(negedge clock); a_thr = 10'd4; a_valid = 1'b1; a_vpf = 768'hF;
    @(negedge clock); a_vpf = 768'h1F;
    @(negedge clock); a_vpf = 768'h7;
    @(negedge clock); a_valid = 1'b0; a_vpf = '0;
    repeat (LAT_A - 3) @(negedge clock);
    check("seq_cnt4", 32'(a_cnt_o), 4);
    check("seq_ovf4", 32'(a_ovf_o), 0);
    @(negedge clock);
    check("seq_cnt5", 32'(a_cnt_o), 5);
    check("seq_ovf5", 32'(a_ovf_o), 1);
    check("seq_pk4",  32'(a_peak_o), 4);
    @(negedge clock);
    check("seq_cnt3", 32'(a_cnt_o), 3);
    check("seq_ovf3", 32'(a_ovf_o), 0);
    check("seq_pk5",  32'(a_peak_o), 5);
    check("seq_oc1",  32'(a_ovfc_o), 1);
    a_clear = 1'b1;
    @(negedge clock);
    a_clear = 1'b0;
    check("seq_clr_pk", 32'(a_peak_o), 3);
    check("seq_clr_oc", 32'(a_ovfc_o), 0);

    // Threshold travels with its word.
    @(negedge clock); a_thr = 10'd4; a_valid = 1'b1; a_vpf = 768'h1F;
    @(negedge clock); a_thr = 10'd5;
    @(negedge clock); a_thr = 10'd0; a_valid = 1'b0; a_vpf = '0;
    repeat (LAT_A - 2) @(negedge clock);
    check("thr_ovf_a", 32'(a_ovf_o), 1);
    @(negedge clock);
    check("thr_ovf_b", 32'(a_ovf_o), 0);
    check("thr_cnt_b", 32'(a_cnt_o), 5);
    @(negedge clock);
    check("thr_oc", 32'(a_ovfc_o), 1);

    // Saturation with a 2-bit counter.
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    check("sat_rst_oc", 32'(c_ovfc_o), 0);
    for (int i = 0; i < 5; i++) begin
      a_vpf = ones; a_thr = 10'd0; a_valid = 1'b1;
      @(negedge clock);
    end
    a_valid = 1'b0; a_vpf = '0;
    repeat (LAT_A - 5) @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("sat_c%0d", k), 32'(c_ovfc_o), (k < 3) ? k + 1 : 3);
      check($sformatf("sat_a%0d", k), 32'(a_ovfc_o), k + 1);
    end

    // Reset with five words in flight.
    for (int i = 0; i < 5; i++) begin
      a_vpf = 768'hF; a_thr = 10'd0; a_valid = 1'b1;
      @(negedge clock);
    end
    a_valid = 1'b0; a_vpf = '0; reset = 1'b1;
    @(negedge clock);
    check("mid_rst_cnt",   32'(a_cnt_o), 0);
    check("mid_rst_ovf",   32'(a_ovf_o), 0);
    check("mid_rst_valid", 32'(a_valid_o), 0);
    check("mid_rst_peak",  32'(a_peak_o), 0);
    check("mid_rst_ovfc",  32'(a_ovfc_o), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (a_valid_o) seen++;
    end
    check("mid_rst_no_valid", 32'(seen), 0);
    send_a(768'h7F, 10'd6, 10'd7, 1'b1, 10'd7, 16'd1, "post_rst");

    // WIDTH=100: walking one then all-ones, streamed back to back.
    for (int j = 0; j <= 100 + LAT_B; j++) begin
      @(negedge clock);
      if (j == LAT_B - 1) check("b_early_valid", 32'(b_valid_o), 0);
      if (j >= LAT_B) begin
        check($sformatf("b_valid%0d", j - LAT_B), 32'(b_valid_o), 1);
        check($sformatf("b_cnt%0d", j - LAT_B), 32'(b_cnt_o), (j - LAT_B == 100) ? 100 : 1);
        check($sformatf("b_ovf%0d", j - LAT_B), 32'(b_ovf_o), (j - LAT_B == 100) ? 1 : 0);
      end
      if (j < 100) begin
        b_vpf = '0; b_vpf[j] = 1'b1; b_valid = 1'b1;
      end else if (j == 100) begin
        b_vpf = '1; b_valid = 1'b1;
      end else begin
        b_vpf = '0; b_valid = 1'b0;
      end
    end
    @(negedge clock);
    check("b_peak", 32'(b_peak_o), 100);
    check("b_ovfc", 32'(b_ovfc_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
